interp_sched: RTL and testbench



---
 rtl/interp_sched_if.sv | 25 ++
 rtl/interp_sched.sv | 210 +++++++++++++++++++++
 tb/tb_interp_sched.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/interp_sched_if.sv
// Handshake and bus signals between the interpolation sequencer, the shared
// divider and the equalizer. The master modport is the sequencer side.
interface interp_sched_if;
    logic       start;
    logic       div_req;
    logic [2:0] div_sym;
    logic [3:0] div_sc;
    logic       div_done;
    logic [1:0] sel;
    logic       h_valid;
    logic       h_ready;
    logic       busy;
    logic       slot_done;
    logic       tmo_err;

    modport master (
        input  start, div_done, h_ready,
        output div_req, div_sym, div_sc, sel, h_valid, busy, slot_done, tmo_err
    );

    modport slave (
        output start, div_done, h_ready,
        input  div_req, div_sym, div_sc, sel, h_valid, busy, slot_done, tmo_err
    );
endinterface

// File: rtl/interp_sched.sv
// interp_sched: walks every (symbol, subcarrier) position of one slot,
// requests interpolated values from the shared divider for non-pilot symbols
// and presents each coefficient to the equalizer over valid/ready.
// Optional feature: define INTERP_SCHED_TIMEOUT_EN to bound the divider wait
// to TMO cycles, falling back to a pilot estimate and raising sticky tmo_err.
module interp_sched #(
    parameter int NSYM = 7,
    parameter int NSC  = 12,
    parameter int P1   = 5,
    parameter int P2   = 6,
    parameter int TMO  = 64
) (
    input  logic           clk,
    input  logic           rst_n,
    interp_sched_if.master bus
);
    typedef enum logic [2:0] {S_IDLE, S_REQ, S_WAIT, S_OUT, S_DONE} state_t;

    localparam logic [2:0] P1_C       = 3'(P1);
    localparam logic [2:0] P2_C       = 3'(P2);
    localparam logic [2:0] NSYM_LAST  = 3'(NSYM - 1);
    localparam logic [3:0] NSC_LAST   = 4'(NSC - 1);

    state_t     state_q, state_d;
    logic [2:0] sym_q, sym_d;
    logic [3:0] sc_q, sc_d;
    logic [1:0] sel_q, sel_d;
    logic       div_req_q, div_req_d;
    logic       h_valid_q, h_valid_d;
    logic       busy_q, busy_d;
    logic       slot_done_q, slot_done_d;
    logic [2:0] nxt_sym_s;
    logic [3:0] nxt_sc_s;
    logic       last_pos_s;

    // Pilot symbols carry their own estimate and need no divider request.
    function automatic logic is_pilot(input logic [2:0] s);
        return (s == P1_C) || (s == P2_C);
    endfunction

    // Coefficient source for a symbol: pilots, then early or late interpolation.
    function automatic logic [1:0] sel_for(input logic [2:0] s);
        logic [1:0] r;
        if (s == P1_C)     r = 2'b00;
        else if (s == P2_C) r = 2'b10;
        else if (s < P1_C)  r = 2'b11;
        else                r = 2'b01;
        return r;
    endfunction

`ifdef INTERP_SCHED_TIMEOUT_EN
    localparam int              TW       = $clog2(TMO + 1);
    localparam logic [TW-1:0]   TMO_LAST = TW'(TMO - 1);

    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic          tmo_err_q, tmo_err_d;

    // Nearest pilot estimate used when the divider never answers.
    function automatic logic [1:0] fallback_sel(input logic [2:0] s);
        return (s < P1_C) ? 2'b00 : 2'b10;
    endfunction

    assign bus.tmo_err = tmo_err_q;
`else
    localparam int unused_tmo = TMO;
    assign bus.tmo_err = 1'b0;
`endif

    // Position following the current one, and whether the current is the last.
    always_comb begin
        nxt_sym_s  = sym_q;
        nxt_sc_s   = sc_q + 4'd1;
        last_pos_s = (sym_q == NSYM_LAST) && (sc_q == NSC_LAST);
        if (sc_q == NSC_LAST) begin
            nxt_sc_s  = 4'd0;
            nxt_sym_s = sym_q + 3'd1;
        end else begin
            nxt_sc_s  = sc_q + 4'd1;
        end
    end

    // Next-state and registered-output computation for the slot sequencer.
    always_comb begin
        state_d     = state_q;
        sym_d       = sym_q;
        sc_d        = sc_q;
        sel_d       = sel_q;
        div_req_d   = 1'b0;
        h_valid_d   = 1'b0;
        slot_done_d = 1'b0;
`ifdef INTERP_SCHED_TIMEOUT_EN
        tmo_cnt_d   = tmo_cnt_q;
        tmo_err_d   = tmo_err_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (bus.start) begin
                    sym_d = 3'd0;
                    sc_d  = 4'd0;
`ifdef INTERP_SCHED_TIMEOUT_EN
                    tmo_err_d = 1'b0;
`endif
                    if (is_pilot(3'd0)) begin
                        state_d   = S_OUT;
                        h_valid_d = 1'b1;
                        sel_d     = sel_for(3'd0);
                    end else begin
                        state_d   = S_REQ;
                        div_req_d = 1'b1;
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_REQ: begin
                state_d = S_WAIT;
`ifdef INTERP_SCHED_TIMEOUT_EN
                tmo_cnt_d = '0;
`endif
            end
            S_WAIT: begin
                if (bus.div_done) begin
                    state_d   = S_OUT;
                    h_valid_d = 1'b1;
                    sel_d     = sel_for(sym_q);
`ifdef INTERP_SCHED_TIMEOUT_EN
                end else if (tmo_cnt_q == TMO_LAST) begin
                    state_d   = S_OUT;
                    h_valid_d = 1'b1;
                    sel_d     = fallback_sel(sym_q);
                    tmo_err_d = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + TW'(1);
`else
                end else begin
                    state_d = S_WAIT;
`endif
                end
            end
            S_OUT: begin
                if (bus.h_ready) begin
                    if (last_pos_s) begin
                        state_d     = S_DONE;
                        slot_done_d = 1'b1;
                    end else begin
                        sym_d = nxt_sym_s;
                        sc_d  = nxt_sc_s;
                        if (is_pilot(nxt_sym_s)) begin
                            state_d   = S_OUT;
                            h_valid_d = 1'b1;
                            sel_d     = sel_for(nxt_sym_s);
                        end else begin
                            state_d   = S_REQ;
                            div_req_d = 1'b1;
                        end
                    end
                end else begin
                    state_d   = S_OUT;
                    h_valid_d = 1'b1;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
        busy_d = (state_d != S_IDLE);
    end

    // State, counters and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            sym_q       <= 3'd0;
            sc_q        <= 4'd0;
            sel_q       <= 2'b00;
            div_req_q   <= 1'b0;
            h_valid_q   <= 1'b0;
            busy_q      <= 1'b0;
            slot_done_q <= 1'b0;
`ifdef INTERP_SCHED_TIMEOUT_EN
            tmo_cnt_q   <= '0;
            tmo_err_q   <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            sym_q       <= sym_d;
            sc_q        <= sc_d;
            sel_q       <= sel_d;
            div_req_q   <= div_req_d;
            h_valid_q   <= h_valid_d;
            busy_q      <= busy_d;
            slot_done_q <= slot_done_d;
`ifdef INTERP_SCHED_TIMEOUT_EN
            tmo_cnt_q   <= tmo_cnt_d;
            tmo_err_q   <= tmo_err_d;
`endif
        end
    end

    assign bus.div_req   = div_req_q;
    assign bus.div_sym   = sym_q;
    assign bus.div_sc    = sc_q;
    assign bus.sel       = sel_q;
    assign bus.h_valid   = h_valid_q;
    assign bus.busy      = busy_q;
    assign bus.slot_done = slot_done_q;
endmodule

// File: tb/tb_interp_sched.sv
// Bench for interp_sched: two instances (default pilots, and P1=0), one active
// at a time, driven with randomized divider latency and equalizer back-pressure
// and checked against a slot-level reference list of expected coefficients.
module tb_interp_sched;
    localparam int NSYM  = 7;
    localparam int NSC   = 12;
    localparam int TMO_A = 8;

    typedef struct {
        int       sym;
        int       sc;
        logic [1:0] sel;
        bit       div;
    } coef_t;

    logic clk;
    logic rst_n;
    logic which;
    logic start_s, div_done_s, h_ready_s;

    interp_sched_if if_a ();
    interp_sched_if if_b ();

    interp_sched #(.TMO(TMO_A)) dut_a (.clk(clk), .rst_n(rst_n), .bus(if_a));
    interp_sched #(.P1(0), .P2(6)) dut_b (.clk(clk), .rst_n(rst_n), .bus(if_b));

    assign if_a.start    = start_s & ~which;
    assign if_b.start    = start_s & which;
    assign if_a.div_done = div_done_s & ~which;
    assign if_b.div_done = div_done_s & which;
    assign if_a.h_ready  = h_ready_s;
    assign if_b.h_ready  = h_ready_s;

    logic       o_dreq, o_hv, o_busy, o_sdone, o_tmo;
    logic [1:0] o_sel;
    logic [2:0] o_sym;
    logic [3:0] o_sc;
    assign o_dreq  = which ? if_b.div_req   : if_a.div_req;
    assign o_hv    = which ? if_b.h_valid   : if_a.h_valid;
    assign o_busy  = which ? if_b.busy      : if_a.busy;
    assign o_sdone = which ? if_b.slot_done : if_a.slot_done;
    assign o_tmo   = which ? if_b.tmo_err   : if_a.tmo_err;
    assign o_sel   = which ? if_b.sel       : if_a.sel;
    assign o_sym   = which ? if_b.div_sym   : if_a.div_sym;
    assign o_sc    = which ? if_b.div_sc    : if_a.div_sc;

    int total = 0;
    int bad   = 0;
    bit tmo_exp = 1'b0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Reference coefficient source, straight from the select table.
    function automatic logic [1:0] ref_sel(input int p1, input int p2, input int s);
        if (s == p1)      return 2'b00;
        else if (s == p2) return 2'b10;
        else if (s < p1)  return 2'b11;
        else              return 2'b01;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_div_req"}, o_dreq, 0);
        check({tag, "_h_valid"}, o_hv, 0);
        check({tag, "_busy"}, o_busy, 0);
        check({tag, "_slot_done"}, o_sdone, 0);
        check({tag, "_sel"}, o_sel, 0);
        check({tag, "_div_sym"}, o_sym, 0);
        check({tag, "_div_sc"}, o_sc, 0);
        check({tag, "_tmo_err"}, o_tmo, 0);
    endtask

    task automatic run_slot(input bit b, input int ready_pct, input bit stall,
                            input bit busy_start, input bit abort, input bit tmo_first);
        coef_t q[$];
        coef_t c, head;
        int p1, p2, n_div, cyc, req_cnt, hs_cnt, sdone_cnt;
        int hv_due, req_due, done_at, tmo_at, done_cyc, stall_left;
        bit req_pend, finished, bs_done, abort_pending, tmo_ovr, exp_dreq, exp_hv, rdy;
        logic [1:0] exp_sel;

        p1 = b ? 0 : 5;
        p2 = 6;
        n_div = 0;
        for (int s = 0; s < NSYM; s++) begin
            for (int k = 0; k < NSC; k++) begin
                c.sym = s; c.sc = k; c.sel = ref_sel(p1, p2, s);
                c.div = !((s == p1) || (s == p2));
                if (c.div) n_div++;
                q.push_back(c);
            end
        end
        req_cnt = 0; hs_cnt = 0; sdone_cnt = 0; done_at = -1; tmo_at = -1; done_cyc = -1;
        stall_left = 5; req_pend = 0; finished = 0; bs_done = 0; abort_pending = 0; tmo_ovr = 0;

        @(negedge clk);
        which = b;
        start_s = 1'b1; div_done_s = 1'b0; h_ready_s = 1'b0;
        cyc = 0;
        hv_due  = q[0].div ? -1 : 1;
        req_due = q[0].div ? 1 : -1;

        while (!finished && cyc < 4000) begin
            @(negedge clk);
            cyc++;
            start_s = 1'b0; div_done_s = 1'b0; h_ready_s = 1'b0;
            if (abort_pending) begin
                rst_n = 1'b0;
                #1;
                check_reset_outputs("mid_slot_reset");
                tmo_exp = 1'b0;
                @(negedge clk);
                rst_n = 1'b1;
                return;
            end
            if (cyc == 1) tmo_exp = 1'b0;
            if (tmo_at > 0 && cyc >= tmo_at) tmo_exp = 1'b1;
            check("tmo_err", o_tmo, tmo_exp);

            if (q.size() == 0) begin
                if (cyc == done_cyc) begin
                    check("slot_done_pulse", o_sdone, 1);
                    check("busy_in_done", o_busy, 1);
                    check("h_valid_in_done", o_hv, 0);
                    check("div_req_in_done", o_dreq, 0);
                end else begin
                    check("slot_done_after", o_sdone, 0);
                    check("busy_after", o_busy, 0);
                    finished = 1;
                end
                if (o_sdone) sdone_cnt++;
                continue;
            end

            head = q[0];
            exp_dreq = head.div && !req_pend && (cyc == req_due);
            check("div_req", o_dreq, exp_dreq);
            if (o_dreq) begin
                req_cnt++;
                check("req_sym", o_sym, head.sym);
                check("req_sc", o_sc, head.sc);
                if (exp_dreq) begin
                    req_pend = 1;
                    if (tmo_first && req_cnt == 1) begin
                        tmo_at  = cyc + TMO_A + 1;
                        hv_due  = tmo_at;
                        tmo_ovr = 1;
                    end else begin
                        done_at = cyc + $urandom_range(1, 4);
                        hv_due  = done_at + 1;
                    end
                    if (abort && head.sym == 1 && head.sc == 4) abort_pending = 1;
                end
            end
            if (cyc == done_at) div_done_s = 1'b1;

            exp_hv = (hv_due >= 0) && (cyc >= hv_due);
            check("h_valid", o_hv, exp_hv);
            check("busy", o_busy, 1);
            check("slot_done_early", o_sdone, 0);

            if (o_hv) begin
                exp_sel = tmo_ovr ? ((head.sym < p1) ? 2'b00 : 2'b10) : head.sel;
                check("sel", o_sel, exp_sel);
                check("out_sym", o_sym, head.sym);
                check("out_sc", o_sc, head.sc);
                if ($urandom_range(0, 3) == 0) div_done_s = 1'b1;
                if (stall && head.sym == 2 && head.sc == 7 && stall_left > 0) begin
                    rdy = 0;
                    stall_left--;
                end else begin
                    rdy = ($urandom_range(0, 99) < ready_pct);
                end
                h_ready_s = rdy;
                if (rdy) begin
                    hs_cnt++;
                    void'(q.pop_front());
                    tmo_ovr = 0;
                    req_pend = 0;
                    if (q.size() == 0) begin
                        done_cyc = cyc + 1;
                    end else if (q[0].div) begin
                        req_due = cyc + 1;
                        hv_due  = -1;
                    end else begin
                        hv_due  = cyc + 1;
                        req_due = -1;
                    end
                end
            end
            if (busy_start && !bs_done && head.sym == 3 && head.sc == 0) begin
                start_s = 1'b1;
                bs_done = 1;
            end
        end
        check("slot_finished", finished, 1);
        check("handshakes", hs_cnt, NSYM * NSC);
        check("div_req_count", req_cnt, n_div);
        check("slot_done_count", sdone_cnt, 1);
    endtask

    initial begin
        rst_n = 1'b0; which = 1'b0;
        start_s = 1'b0; div_done_s = 1'b0; h_ready_s = 1'b0;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset_a");
        which = 1'b1;
        #1;
        check_reset_outputs("reset_b");
        rst_n = 1'b1;

        run_slot(1'b0, 100, 1'b0, 1'b0, 1'b0, 1'b0);
        run_slot(1'b0, 100, 1'b1, 1'b0, 1'b0, 1'b0);
        run_slot(1'b0, 60,  1'b0, 1'b1, 1'b0, 1'b0);
        run_slot(1'b0, 100, 1'b0, 1'b0, 1'b1, 1'b0);
        run_slot(1'b0, 80,  1'b0, 1'b0, 1'b0, 1'b0);
        run_slot(1'b1, 100, 1'b0, 1'b0, 1'b0, 1'b0);
        run_slot(1'b1, 70,  1'b1, 1'b1, 1'b0, 1'b0);
`ifdef INTERP_SCHED_TIMEOUT_EN
        run_slot(1'b0, 100, 1'b0, 1'b0, 1'b0, 1'b1);
        run_slot(1'b0, 100, 1'b0, 1'b0, 1'b0, 1'b0);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
